// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_pkg
//  Purpose  : Shared constants for the RV32I instruction sequencer:
//             base opcodes, sequencer state encoding, instruction size and
//             a helper classifying opcodes that go straight to execute.
//  Revision : 1.0  initial release
// ============================================================================
package rv32i_pkg;

  // Base RV32I major opcodes handled by the sequencer
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_COMP = 7'b0010011;
  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B      = 7'b1100011;

  localparam int unsigned INS_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_LDMEM  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_STMEM  = 3'd5,
    ST_COMMIT = 3'd6,
    ST_FAULT  = 3'd7
  } seq_state_e;

  // Opcodes that need no operand load before the exec strobe. Stores go
  // through exec first so the unit can produce address/data.
  function automatic logic is_exec_op(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I_COMP) || (op == OP_S) || (op == OP_B);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ins_seq_timer.sv
`default_nettype none
// ============================================================================
//  Module   : ins_seq_timer
//  Purpose  : Memory-handshake wait counter. Cleared while clr_i is high,
//             counts cycles while en_i is high. expire_o flags the last
//             permitted waiting cycle (count == LIMIT-1).
//  Ports    : clk_i, rst_i (async, active-high), clr_i, en_i, expire_o
//  Revision : 1.0  initial release
// ============================================================================
module ins_seq_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + CW'(1);
    end
  end

  // Asserted during the LIMIT-th waiting cycle; if no ack arrives in that
  // cycle the sequencer faults on the same edge.
  assign expire_o = (count_q == CW'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/ins_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ins_seq_ctrl
//  Purpose  : Multi-cycle RV32I sequencer. Fetches, latches the instruction
//             for the decoder, strobes the execute unit, runs the data
//             memory handshake and commits PC / register-file writes.
//  Ports    : sys_clk, sys_rst (async, active-high), run,
//             imem_req/addr/ack/rdata, ins_word, dec_op, exec_op,
//             ex_reg_w_op/ex_mem_w_op/ex_pc_w_op/ex_pc_w_val,
//             dmem_req/we/ack, rf_we, pc, halted, fault
//             [perf_cycle, perf_retire when INS_SEQ_PERF_CNT_EN is defined]
//  Config   : INS_SEQ_PERF_CNT_EN - adds cycle / retire performance counters
//  Revision : 1.0  initial release
// ============================================================================
module ins_seq_ctrl
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins_word,
  input  logic [6:0]  dec_op,
  output logic        exec_op,
  input  logic        ex_reg_w_op,
  input  logic        ex_mem_w_op,
  input  logic        ex_pc_w_op,
  input  logic [31:0] ex_pc_w_val,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        halted,
`ifdef INS_SEQ_PERF_CNT_EN
  output logic [31:0] perf_cycle,
  output logic [31:0] perf_retire,
`endif
  output logic        fault
);

  seq_state_e  state_q;
  logic [31:0] pc_q;
  logic [31:0] ins_word_q;
  logic        imem_req_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic        exec_op_q;
  logic        rf_we_q;
  logic        halted_q;
  logic        fault_q;
  // Exec results captured when leaving EXEC, used at COMMIT
  logic        reg_w_q;
  logic        pc_w_q;
  logic [31:0] pc_val_q;

  logic [31:0] pc_d;
  logic        mem_wait;
  logic        mem_ack;
  logic        tmr_clr;
  logic        tmr_en;
  logic        tmr_expire;

  assign pc_d = pc_w_q ? pc_val_q : (pc_q + 32'(INS_BYTES));

  // Wait states are never adjacent, so holding the timer clear in every
  // other state guarantees a zero count on entry to each handshake.
  assign mem_wait = (state_q == ST_FETCH) || (state_q == ST_LDMEM) ||
                    (state_q == ST_STMEM);
  assign mem_ack  = (state_q == ST_FETCH) ? imem_ack : dmem_ack;
  assign tmr_clr  = !mem_wait || mem_ack;
  assign tmr_en   = mem_wait && !mem_ack;

  ins_seq_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timer (
    .clk_i    (sys_clk),
    .rst_i    (sys_rst),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      ins_word_q <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      exec_op_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      halted_q   <= 1'b1;
      fault_q    <= 1'b0;
      reg_w_q    <= 1'b0;
      pc_w_q     <= 1'b0;
      pc_val_q   <= '0;
    end else begin
      // Single-cycle strobes default low
      exec_op_q <= 1'b0;
      rf_we_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q    <= ST_FETCH;
            imem_req_q <= 1'b1;
            halted_q   <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (imem_ack) begin
            ins_word_q <= imem_rdata;
            imem_req_q <= 1'b0;
            state_q    <= ST_DECODE;
          end else if (tmr_expire) begin
            imem_req_q <= 1'b0;
            fault_q    <= 1'b1;
            halted_q   <= 1'b1;
            state_q    <= ST_FAULT;
          end
        end
        ST_DECODE: begin
          if (dec_op == OP_LD) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= 1'b0;
            state_q    <= ST_LDMEM;
          end else if (is_exec_op(dec_op)) begin
            exec_op_q <= 1'b1;
            state_q   <= ST_EXEC;
          end else begin
            fault_q  <= 1'b1;
            halted_q <= 1'b1;
            state_q  <= ST_FAULT;
          end
        end
        ST_LDMEM: begin
          if (dmem_ack) begin
            dmem_req_q <= 1'b0;
            exec_op_q  <= 1'b1;
            state_q    <= ST_EXEC;
          end else if (tmr_expire) begin
            dmem_req_q <= 1'b0;
            fault_q    <= 1'b1;
            halted_q   <= 1'b1;
            state_q    <= ST_FAULT;
          end
        end
        ST_EXEC: begin
          // Exec unit registered its results on the negedge of this cycle
          reg_w_q  <= ex_reg_w_op;
          pc_w_q   <= ex_pc_w_op;
          pc_val_q <= ex_pc_w_val;
          if (ex_mem_w_op) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= 1'b1;
            state_q    <= ST_STMEM;
          end else begin
            rf_we_q <= ex_reg_w_op;
            state_q <= ST_COMMIT;
          end
        end
        ST_STMEM: begin
          if (dmem_ack) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= reg_w_q;
            state_q    <= ST_COMMIT;
          end else if (tmr_expire) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            fault_q    <= 1'b1;
            halted_q   <= 1'b1;
            state_q    <= ST_FAULT;
          end
        end
        ST_COMMIT: begin
          pc_q <= pc_d;
          if (run) begin
            imem_req_q <= 1'b1;
            state_q    <= ST_FETCH;
          end else begin
            halted_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        ST_FAULT: begin
          // Sticky until reset
          state_q <= ST_FAULT;
        end
        default: begin
          fault_q  <= 1'b1;
          halted_q <= 1'b1;
          state_q  <= ST_FAULT;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign ins_word  = ins_word_q;
  assign exec_op   = exec_op_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign rf_we     = rf_we_q;
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign fault     = fault_q;

`ifdef INS_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycle_q;
  logic [31:0] perf_retire_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      perf_cycle_q  <= '0;
      perf_retire_q <= '0;
    end else begin
      if ((state_q != ST_IDLE) && (state_q != ST_FAULT)) begin
        perf_cycle_q <= perf_cycle_q + 32'd1;
      end
      if (state_q == ST_COMMIT) begin
        perf_retire_q <= perf_retire_q + 32'd1;
      end
    end
  end

  assign perf_cycle  = perf_cycle_q;
  assign perf_retire = perf_retire_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ins_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ins_seq_ctrl
//  Purpose  : Self-checking bench for ins_seq_ctrl. The bench plays the
//             instruction memory, decoder, execute unit and data memory;
//             expectations come from a per-instruction transaction model
//             (opcode class -> strobes, memory accesses, latency, next PC).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ins_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TMO    = 16;

  localparam logic [31:0] W_ADD  = 32'h0020_81B3;
  localparam logic [31:0] W_ADDI = 32'h0010_8093;
  localparam logic [31:0] W_LW   = 32'h0000_A103;
  localparam logic [31:0] W_SW   = 32'h0020_A023;
  localparam logic [31:0] W_BEQ  = 32'h0020_8463;
  localparam logic [31:0] W_BAD  = 32'h0000_007F;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        run = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ins_word;
  logic [6:0]  dec_op;
  logic        exec_op;
  logic        ex_reg_w_op = 1'b0;
  logic        ex_mem_w_op = 1'b0;
  logic        ex_pc_w_op = 1'b0;
  logic [31:0] ex_pc_w_val = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack = 1'b0;
  logic        rf_we;
  logic [31:0] pc;
  logic        halted;
  logic        fault;
`ifdef INS_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycle;
  logic [31:0] perf_retire;
`endif

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [31:0] model_pc;
  int          exp_retire;
  int          exp_cycles;

  // Decoder stand-in: major opcode field of the latched word
  assign dec_op = ins_word[6:0];

  always #5 sys_clk = ~sys_clk;

  ins_seq_ctrl #(
    .RESET_PC    (RST_PC),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ins_word    (ins_word),
    .dec_op      (dec_op),
    .exec_op     (exec_op),
    .ex_reg_w_op (ex_reg_w_op),
    .ex_mem_w_op (ex_mem_w_op),
    .ex_pc_w_op  (ex_pc_w_op),
    .ex_pc_w_val (ex_pc_w_val),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ack    (dmem_ack),
    .rf_we       (rf_we),
    .pc          (pc),
    .halted      (halted),
`ifdef INS_SEQ_PERF_CNT_EN
    .perf_cycle  (perf_cycle),
    .perf_retire (perf_retire),
`endif
    .fault       (fault)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    sys_rst  = 1'b1;
    run      = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst    = 1'b0;
    model_pc   = RST_PC;
    exp_retire = 0;
    exp_cycles = 0;
  endtask

  task automatic wait_fetch(input string tag);
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chk1(tag, imem_req, 1'b1);
  endtask

  // Runs one instruction from its first FETCH cycle to the next FETCH
  // (or IDLE / FAULT) and compares against the transaction model.
  task automatic do_instr(input string tag, input logic [31:0] word, input int fdly,
                          input int mdly, input bit taken, input logic [31:0] target,
                          input bit drop_run);
    logic [6:0]  opc;
    bit          is_ld, is_st, is_br, is_alu, legal, fetched, mem_seen, order_ok, we_seen;
    int          fw, dw, cyc, n_exec, n_rf, n_dm, exp_cyc;
    logic [31:0] exp_next;

    opc    = word[6:0];
    is_ld  = (opc == 7'b0000011);
    is_st  = (opc == 7'b0100011);
    is_br  = (opc == 7'b1100011);
    is_alu = (opc == 7'b0110011) || (opc == 7'b0010011);
    legal  = is_ld || is_st || is_br || is_alu;

    exp_next = (is_br && taken) ? target : model_pc + 32'd4;
    if (!legal)              exp_cyc = fdly + 2;
    else if (is_ld || is_st) exp_cyc = 5 + fdly + mdly;
    else                     exp_cyc = 4 + fdly;

    // Execute-unit results for this instruction
    ex_reg_w_op = is_alu || is_ld;
    ex_mem_w_op = is_st;
    ex_pc_w_op  = is_br && taken;
    ex_pc_w_val = target;
    imem_rdata  = word;

    wait_fetch({tag, "_req"});
    chk32({tag, "_addr"}, imem_addr, model_pc);

    fw = 0; dw = 0; cyc = 0; n_exec = 0; n_rf = 0; n_dm = 0;
    fetched = 0; mem_seen = 0; order_ok = 1; we_seen = 0;
    forever begin
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (imem_req) begin
        if (fw == fdly) begin
          imem_ack = 1'b1;
          fetched  = 1;
        end else begin
          fw++;
        end
      end
      if (dmem_req) begin
        if (!mem_seen) begin
          mem_seen = 1;
          order_ok = is_ld ? (n_exec == 0) : (n_exec == 1);
          if (drop_run) run = 1'b0;
        end
        we_seen = dmem_we;
        if (dw == mdly) begin
          dmem_ack = 1'b1;
          n_dm++;
        end else begin
          dw++;
        end
      end
      if (exec_op) n_exec++;
      if (rf_we)   n_rf++;
      @(negedge sys_clk);
      cyc++;
      if ((fetched && (imem_req || halted)) || cyc >= 80) break;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;

    chk32({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk32({tag, "_insword"}, ins_word, word);
    if (!legal) begin
      chk1({tag, "_fault"}, fault, 1'b1);
      chk1({tag, "_halted"}, halted, 1'b1);
      chk32({tag, "_nexec"}, 32'(n_exec), 32'd0);
      chk1({tag, "_noreq"}, imem_req, 1'b0);
    end else begin
      chk32({tag, "_nexec"}, 32'(n_exec), 32'd1);
      chk32({tag, "_nrf"}, 32'(n_rf), (is_alu || is_ld) ? 32'd1 : 32'd0);
      chk32({tag, "_ndmem"}, 32'(n_dm), (is_ld || is_st) ? 32'd1 : 32'd0);
      if (is_ld || is_st) begin
        chk1({tag, "_dmem_we"}, we_seen, is_st);
        chk1({tag, "_dmem_order"}, order_ok, 1'b1);
      end
      chk32({tag, "_pc"}, pc, exp_next);
      chk1({tag, "_fault"}, fault, 1'b0);
      if (drop_run) begin
        chk1({tag, "_idle"}, halted, 1'b1);
        chk1({tag, "_idle_noreq"}, imem_req, 1'b0);
      end else begin
        chk1({tag, "_refetch"}, imem_req, 1'b1);
        chk32({tag, "_refetch_addr"}, imem_addr, exp_next);
      end
      model_pc = exp_next;
      exp_retire++;
    end
    exp_cycles += exp_cyc;
  endtask

  initial begin
    logic [31:0] words [5];
    int          tmo_seen;
    words[0] = W_ADD; words[1] = W_ADDI; words[2] = W_LW; words[3] = W_SW; words[4] = W_BEQ;

    // ---------------- reset state ----------------
    reset_dut();
    chk1("rst_halted", halted, 1'b1);
    chk1("rst_fault", fault, 1'b0);
    chk32("rst_pc", pc, RST_PC);
    chk32("rst_insword", ins_word, 32'd0);
    chk1("rst_imem_req", imem_req, 1'b0);
    chk1("rst_dmem_req", dmem_req, 1'b0);
    chk1("rst_exec_op", exec_op, 1'b0);
    chk1("rst_rf_we", rf_we, 1'b0);

    // ---------------- directed instruction stream ----------------
    run = 1'b1;
    do_instr("add",      W_ADD,  2, 0, 1'b0, 32'h0,        1'b0);
    do_instr("lw",       W_LW,   0, 1, 1'b0, 32'h0,        1'b0);
    do_instr("sw",       W_SW,   1, 3, 1'b0, 32'h0,        1'b0);
    do_instr("beq_tk",   W_BEQ,  0, 0, 1'b1, 32'h0000_0040, 1'b0);
    do_instr("beq_nt",   W_BEQ,  1, 0, 1'b0, 32'h0000_0400, 1'b0);
    do_instr("ack_edge", W_ADDI, TMO - 1, 0, 1'b0, 32'h0,  1'b0);
    do_instr("ld_edge",  W_LW,   0, TMO - 1, 1'b0, 32'h0,  1'b0);

    // ---------------- randomized stream ----------------
    for (int i = 0; i < 24; i++) begin
      do_instr("rnd", words[$urandom_range(0, 4)], $urandom_range(0, 4),
               $urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom, 1'b0);
    end

    // ---------------- PC wrap ----------------
    do_instr("br_top", W_BEQ, 0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    do_instr("wrap",   W_ADD, 0, 0, 1'b0, 32'h0,         1'b0);
    chk32("wrap_pc_zero", pc, 32'h0);

    // ---------------- run dropped during LDMEM ----------------
    do_instr("lw_drop", W_LW, 1, 2, 1'b0, 32'h0, 1'b1);
    repeat (3) @(negedge sys_clk);
    chk1("drop_stays_idle", halted, 1'b1);
    chk1("drop_no_fetch", imem_req, 1'b0);
`ifdef INS_SEQ_PERF_CNT_EN
    chk32("perf_retire", perf_retire, 32'(exp_retire));
    chk32("perf_cycle", perf_cycle, 32'(exp_cycles));
`endif

    // ---------------- unsupported opcode ----------------
    run = 1'b1;
    do_instr("bad_op", W_BAD, 0, 0, 1'b0, 32'h0, 1'b0);
    repeat (4) @(negedge sys_clk);
    chk1("bad_op_sticky", fault, 1'b1);
    chk1("bad_op_no_exec", exec_op, 1'b0);
    reset_dut();
    chk1("fault_cleared", fault, 1'b0);
    chk32("fault_pc_reset", pc, RST_PC);

    // ---------------- fetch timeout ----------------
    run = 1'b1;
    wait_fetch("tmo_req");
    tmo_seen = 0;
    for (int i = 0; i < TMO; i++) begin
      if (imem_req) tmo_seen++;
      chk1("tmo_no_early_fault", fault, 1'b0);
      @(negedge sys_clk);
    end
    chk32("tmo_wait_cycles", 32'(tmo_seen), 32'(TMO));
    chk1("tmo_fault", fault, 1'b1);
    chk1("tmo_halted", halted, 1'b1);
    chk1("tmo_req_dropped", imem_req, 1'b0);
    repeat (5) @(negedge sys_clk);
    chk1("tmo_fault_sticky", fault, 1'b1);
    chk1("tmo_req_stays_low", imem_req, 1'b0);

    // ---------------- asynchronous reset mid-handshake ----------------
    reset_dut();
    run = 1'b1;
    wait_fetch("arst_req");
    #2;
    sys_rst = 1'b1;
    #1;
    chk1("arst_req_drop", imem_req, 1'b0);
    chk1("arst_halted", halted, 1'b1);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    run = 1'b0;
    @(negedge sys_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
